// File: rtl/id_fetch_queue.sv
// ---------------------------------------------------------------------------
// id_fetch_queue
//
// Instruction queue between the IF and ID pipeline stages. It buffers
// instruction/PC pairs behind a valid/ready handshake. Each entry is
// pre-classified at enqueue time, so decode can drive the immediate
// generator's type select and its In[31:7] input straight from the head.
// Decode stalls are absorbed until the queue is full. A flush (branch/jump
// redirect) discards everything.
//
// Ports
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear; wins over push and pop in the same cycle
//   if_valid     fetch presents if_instr / if_pc
//   if_instr     fetched instruction word
//   if_pc        PC of if_instr
//   if_ready     queue accepts an entry this cycle (registered state only)
//   id_valid     head entry is valid
//   id_instr     head instruction (NOP when empty)
//   id_pc        head PC (0 when empty)
//   id_imm_type  immediate encoding of head (ITYPE when empty, 7 if illegal)
//   id_illegal   head opcode is not in the supported set
//   id_ready     decode consumes the head this cycle
//   count        current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module id_fetch_queue #(
  parameter int unsigned DEPTH = 4  // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [31:0]              if_pc,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [2:0]               id_imm_type,
  output logic                     id_illegal,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IMM_R   = 3'd0,
    IMM_I   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_U   = 3'd4,
    IMM_J   = 3'd5,
    IMM_BAD = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_type_e   imm_type;
    logic        illegal;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t head;

  // Ready/valid come from the occupancy register only, so if_ready never
  // combinationally depends on id_ready (a full queue refuses a push even
  // when a pop happens in the same cycle).
  assign if_ready = (count_q != CNT_W'(DEPTH));
  assign id_valid = (count_q != '0);
  assign count    = count_q;

  assign push = if_valid && if_ready;
  assign pop  = id_valid && id_ready;

  // -------------------------------------------------------------------------
  // Enqueue-time classification of the RISC-V immediate encoding
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no
    // opcode path can leave it unassigned and infer a latch.
    wr_entry          = '0;
    wr_entry.instr    = if_instr;
    wr_entry.pc       = if_pc;
    wr_entry.imm_type = IMM_I;
    wr_entry.illegal  = 1'b0;
    case (if_instr[6:0])
      7'b0110011:                         wr_entry.imm_type = IMM_R;  // OP
      7'b0010011, 7'b0000011, 7'b1100111: wr_entry.imm_type = IMM_I;  // OP-IMM, LOAD, JALR
      7'b0100011:                         wr_entry.imm_type = IMM_S;  // STORE
      7'b1100011:                         wr_entry.imm_type = IMM_B;  // BRANCH
      7'b0110111, 7'b0010111:             wr_entry.imm_type = IMM_U;  // LUI, AUIPC
      7'b1101111:                         wr_entry.imm_type = IMM_J;  // JAL
      default: begin
        wr_entry.imm_type = IMM_BAD;
        wr_entry.illegal  = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pointer / occupancy next state. Flush drops any push and pop.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; an empty queue forces the
  // head outputs, so stale data is never observable and the array can map
  // onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // -------------------------------------------------------------------------
  // Head outputs: combinational read of registered storage, fixed when empty
  // -------------------------------------------------------------------------
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    if (id_valid) begin
      id_instr    = head.instr;
      id_pc       = head.pc;
      id_imm_type = head.imm_type;
      id_illegal  = head.illegal;
    end else begin
      id_instr    = NOP;
      id_pc       = '0;
      id_imm_type = IMM_I;
      id_illegal  = 1'b0;
    end
  end

endmodule

// File: doc/id_fetch_queue.md
# id_fetch_queue

Instruction queue between the IF stage and the ID stage of the RISC-V pipeline. It buffers fetched instruction/PC pairs behind a valid/ready handshake. For each instruction it pre-classifies the immediate encoding type at enqueue time, so the decode stage can drive the immediate generator's `Type` input and its `In[31:7]` input directly from the queue head. It absorbs decode stalls without stalling fetch until full, and it discards all contents on a branch/jump flush.

## Interface
- `DEPTH`, 4: number of entries; must be a power of two, ≥2.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear (branch/jump redirect from EX).
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  32  fetched instruction word.
- `if_pc`  in  32  PC of `if_instr`.
- `if_ready`  out  1  queue can accept an entry this cycle.
- `id_valid`  out  1  head entry is valid.
- `id_instr`  out  32  head instruction; bits [31:7] feed the immediate generator.
- `id_pc`  out  32  head PC.
- `id_imm_type`  out  3  immediate type of the head entry.
- `id_illegal`  out  1  head opcode is not in the supported set.
- `id_ready`  in  1  decode consumes the head this cycle.
- `count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of {instr[31:0], pc[31:0], imm_type[2:0], illegal}.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is a separate register, 0..DEPTH.
- Push: `if_valid && if_ready`. Write at the write pointer, then increment it.
- Pop: `id_valid && id_ready`. Increment the read pointer.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- `if_ready = (count != DEPTH)`. It depends only on registered state, never on `id_ready`. A push is refused when full, even if a pop occurs in the same cycle.
- `id_valid = (count != 0)`.
- When empty, the head outputs are forced to fixed values:
  - `id_instr` = 32'h00000013 (NOP)
  - `id_pc` = 0
  - `id_imm_type` = ITYPE
  - `id_illegal` = 0
- Classification is computed combinationally from `if_instr[6:0]` and stored with the entry:
  - 0110011 → RTYPE (3'd0)
  - 0010011, 0000011, 1100111 → ITYPE (3'd1)
  - 0100011 → STYPE (3'd2)
  - 1100011 → BTYPE (3'd3)
  - 0110111, 0010111 → UTYPE (3'd4)
  - 1101111 → JTYPE (3'd5)
  - any other opcode → type 3'd7 with illegal = 1
- Flush: next edge sets count = 0 and both pointers = 0. It has priority over a push and a pop in the same cycle; both are dropped.
- Reset (asynchronous, any time, including mid-push): count = 0, pointers = 0. Outputs immediately take the empty values: `if_ready` = 1, `id_valid` = 0. Stored entry data is don't-care.

## Timing
- Latency: an entry pushed at edge N appears at the head after edge N (visible in cycle N+1). There is no same-cycle bypass from `if_*` to `id_*`.
- Head outputs are combinational reads of registered storage selected by the read pointer. They change only at clock edges or on reset.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full with `id_ready` = 1: the pop happens and `if_ready` rises in the next cycle, giving one bubble on the fetch side.
- Flush asserted for one cycle: `id_valid` = 0 in the following cycle. A push presented in the flush cycle is lost; fetch re-presents it from the redirected PC.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0 with no gap in ordering.

## Test plan
- Reset then push `0x00500093` (addi, pc 0x0) → next cycle: `id_valid` = 1, `id_imm_type` = 1, `id_pc` = 0, `count` = 1.
- Hold `id_ready` = 0 and push 4 entries (S `0x00112023`, B `0x00208463`, U `0x000012B7`, J `0x008000EF`) → `if_ready` = 0 at count 4. Then pop in order → types 2, 3, 4, 5.
- Keep both sides active for 10 cycles with count = 2 → count stays 2, FIFO order preserved across the pointer wrap, no bubbles.
- Queue at count 3; assert `flush` together with `if_valid` and `id_ready` → next cycle count = 0, `id_valid` = 0, `id_instr` = 0x00000013.
- Push opcode 0x7F → at head: `id_illegal` = 1, `id_imm_type` = 7. Separately, drop `rst_n` between clock edges while count = 2 → `count` = 0 and `id_valid` = 0 before the next edge.
